// File: rtl/store_buffer_pkg.sv
// Shared defaults and types for the store buffer: entry layout and DM port grant encoding.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH      = 4;
  localparam int unsigned SB_AW         = 16;
  localparam int unsigned SB_DW         = 32;
  localparam int unsigned SB_STARVE_MAX = 3;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_DRAIN,
    GNT_FORCE
  } dm_grant_e;

endpackage

// File: rtl/store_buf_fwd.sv
// Combinational store-to-load forwarding: youngest valid entry whose address matches the load.
module store_buf_fwd
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic [DEPTH-1:0][AW-1:0]   ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]   ent_data,
  input  logic [DEPTH-1:0]           ent_vld,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest so a later match overrides an earlier one.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_vld[idx] && (ent_addr[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue between MEM and a single-ported DM; drains when loads leave the port idle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SB_DEPTH,
  parameter int unsigned AW         = SB_AW,
  parameter int unsigned DW         = SB_DW,
  parameter int unsigned STARVE_MAX = SB_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_vld,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_rdy,
  input  logic          ld_vld,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall,
  output logic          dm_we,
  output logic          dm_re,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_vld;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;
  logic [SW-1:0]            starve_cnt;
  dm_grant_e                grant;
  logic                     push;
  logic                     pop;

  assign st_rdy   = (count != CW'(DEPTH));
  assign sb_empty = (count == '0);
  assign push     = st_vld && st_rdy;
  assign pop      = (grant == GNT_FORCE) || (grant == GNT_DRAIN);

  always_comb begin
    grant = GNT_IDLE;
    if ((starve_cnt == SW'(STARVE_MAX)) && !sb_empty) begin
      grant = GNT_FORCE;
    end else if (ld_vld) begin
      grant = GNT_LOAD;
    end else if (!sb_empty) begin
      grant = GNT_DRAIN;
    end
  end

  always_comb begin
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    ld_stall = 1'b0;
    case (grant)
      GNT_FORCE: begin
        dm_we    = 1'b1;
        dm_addr  = ent_addr[head];
        dm_wdata = ent_data[head];
        ld_stall = ld_vld;
      end
      GNT_DRAIN: begin
        dm_we    = 1'b1;
        dm_addr  = ent_addr[head];
        dm_wdata = ent_data[head];
      end
      GNT_LOAD: begin
        dm_re   = 1'b1;
        dm_addr = ld_addr;
      end
      default: ;
    endcase
  end

  // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_vld    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (sb_empty || pop) begin
        starve_cnt <= '0;
      end else if ((grant == GNT_LOAD) && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

  store_buf_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .head     (head),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, backpressure, forwarding, starvation, ordering and wrap.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_vld;
  logic [15:0] st_addr;
  logic [31:0] st_data;
  logic        st_rdy;
  logic        ld_vld;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        dm_we;
  logic        dm_re;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        sb_empty;

  int vectors;
  int miscompares;

  logic [47:0] wlog[$];

  store_buffer #(
    .DEPTH      (4),
    .AW         (16),
    .DW         (32),
    .STARVE_MAX (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_vld   (st_vld),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_rdy   (st_rdy),
    .ld_vld   (ld_vld),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_re    (dm_re),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .sb_empty (sb_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n && dm_we) wlog.push_back({dm_addr, dm_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    st_vld  = 1'b0;
    st_addr = '0;
    st_data = '0;
    ld_vld  = 1'b0;
    ld_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (st_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_st_rdy: got %b want 1", st_rdy); end
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL rst_sb_empty: got %b want 1", sb_empty); end
    vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL rst_dm_we: got %b want 0", dm_we); end
    vectors++; if (dm_re !== 1'b0) begin miscompares++; $display("FAIL rst_dm_re: got %b want 0", dm_re); end
    vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL rst_ld_hit: got %b want 0", ld_hit); end
    vectors++; if (ld_stall !== 1'b0) begin miscompares++; $display("FAIL rst_ld_stall: got %b want 0", ld_stall); end
    vectors++; if (ld_data !== 32'h0) begin miscompares++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
    vectors++; if (dm_addr !== 16'h0) begin miscompares++; $display("FAIL rst_dm_addr: got %h want 0", dm_addr); end
    vectors++; if (dm_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_dm_wdata: got %h want 0", dm_wdata); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_pending();
    wlog.delete();
    st_vld = 1'b1; st_addr = 16'h0040; st_data = 32'h55;
    tick();
    st_addr = 16'h0041; st_data = 32'h66;
    @(negedge clk);
    vectors++; if (dm_we !== 1'b1 || dm_addr !== 16'h0040) begin miscompares++; $display("FAIL rstp_drain0: got we=%b addr=%h want we=1 addr=0040", dm_we, dm_addr); end
    tick();
    idle_in();
    #1;
    vectors++; if (dm_we !== 1'b1 || dm_addr !== 16'h0041) begin miscompares++; $display("FAIL rstp_drain1: got we=%b addr=%h want we=1 addr=0041", dm_we, dm_addr); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL rstp_sb_empty: got %b want 1", sb_empty); end
    vectors++; if (st_rdy !== 1'b1) begin miscompares++; $display("FAIL rstp_st_rdy: got %b want 1", st_rdy); end
    vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL rstp_dm_we: got %b want 0", dm_we); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    vectors++; if (wlog.size() != 1) begin miscompares++; $display("FAIL rstp_write_count: got %0d want 1", wlog.size()); end
    vectors++; if (wlog.size() > 0 && wlog[0] !== {16'h0040, 32'h55}) begin miscompares++; $display("FAIL rstp_write0: got %h want 004000000055", wlog[0]); end
  endtask

  task automatic test_fill();
    logic [47:0] exp_w;
    logic [47:0] got_w;
    wlog.delete();
    ld_vld = 1'b1; ld_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      st_vld = 1'b1; st_addr = 16'h0010 + 16'(i); st_data = 32'hA0 + 32'(i);
      @(negedge clk);
      if (i == 0) begin
        vectors++; if (st_rdy !== 1'b1 || ld_hit !== 1'b0 || dm_re !== 1'b1) begin miscompares++; $display("FAIL fill_first: got rdy=%b hit=%b re=%b want 1 0 1", st_rdy, ld_hit, dm_re); end
      end else if (i == 1) begin
        vectors++; if (ld_hit !== 1'b1 || ld_data !== 32'hA0) begin miscompares++; $display("FAIL fill_fwd: got hit=%b data=%h want 1 a0", ld_hit, ld_data); end
      end else if (i < 4) begin
        vectors++; if (st_rdy !== 1'b1 || dm_we !== 1'b0) begin miscompares++; $display("FAIL fill_hold%0d: got rdy=%b we=%b want 1 0", i, st_rdy, dm_we); end
      end else begin
        vectors++; if (st_rdy !== 1'b0) begin miscompares++; $display("FAIL fill_full_rdy: got %b want 0", st_rdy); end
        vectors++; if (dm_we !== 1'b1 || ld_stall !== 1'b1 || dm_addr !== 16'h0010) begin miscompares++; $display("FAIL fill_force: got we=%b stall=%b addr=%h want 1 1 0010", dm_we, ld_stall, dm_addr); end
      end
      tick();
    end
    idle_in();
    repeat (4) tick();
    @(negedge clk);
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL fill_empty: got %b want 1", sb_empty); end
    vectors++; if (wlog.size() != 4) begin miscompares++; $display("FAIL fill_write_count: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_w = {16'h0010 + 16'(i), 32'hA0 + 32'(i)};
      got_w = (i < wlog.size()) ? wlog[i] : '0;
      vectors++; if (got_w !== exp_w) begin miscompares++; $display("FAIL fill_write%0d: got %h want %h", i, got_w, exp_w); end
    end
    tick();
  endtask

  task automatic test_forward();
    ld_vld = 1'b1; ld_addr = 16'h0021;
    st_vld = 1'b1; st_addr = 16'h0020; st_data = 32'h1111;
    tick();
    st_data = 32'h2222;
    @(negedge clk);
    vectors++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin miscompares++; $display("FAIL fwd_miss_a: got hit=%b data=%h want 0 0", ld_hit, ld_data); end
    tick();
    st_vld = 1'b0; ld_addr = 16'h0020;
    @(negedge clk);
    vectors++; if (ld_hit !== 1'b1 || ld_data !== 32'h2222) begin miscompares++; $display("FAIL fwd_youngest: got hit=%b data=%h want 1 2222", ld_hit, ld_data); end
    tick();
    ld_addr = 16'h0021;
    @(negedge clk);
    vectors++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin miscompares++; $display("FAIL fwd_miss_b: got hit=%b data=%h want 0 0", ld_hit, ld_data); end
    tick();
    ld_addr = 16'h0020;
    @(negedge clk);
    vectors++; if (ld_stall !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'h2222 || dm_wdata !== 32'h1111) begin miscompares++; $display("FAIL fwd_stalled: got stall=%b hit=%b data=%h wdata=%h want 1 1 2222 1111", ld_stall, ld_hit, ld_data, dm_wdata); end
    tick();
    @(negedge clk);
    vectors++; if (ld_stall !== 1'b0 || dm_re !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'h2222) begin miscompares++; $display("FAIL fwd_after: got stall=%b re=%b hit=%b data=%h want 0 1 1 2222", ld_stall, dm_re, ld_hit, ld_data); end
    tick();
    idle_in();
    repeat (2) tick();
    @(negedge clk);
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL fwd_empty: got %b want 1", sb_empty); end
    tick();
  endtask

  task automatic test_starve();
    st_vld = 1'b1; st_addr = 16'h0050; st_data = 32'hBEEF;
    tick();
    idle_in();
    ld_vld = 1'b1; ld_addr = 16'h0050;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++; if (dm_re !== 1'b1 || dm_we !== 1'b0 || ld_stall !== 1'b0 || ld_hit !== 1'b1) begin miscompares++; $display("FAIL starve_load%0d: got re=%b we=%b stall=%b hit=%b want 1 0 0 1", i, dm_re, dm_we, ld_stall, ld_hit); end
      tick();
    end
    @(negedge clk);
    vectors++; if (dm_we !== 1'b1 || dm_re !== 1'b0 || ld_stall !== 1'b1) begin miscompares++; $display("FAIL starve_force: got we=%b re=%b stall=%b want 1 0 1", dm_we, dm_re, ld_stall); end
    vectors++; if (dm_addr !== 16'h0050 || dm_wdata !== 32'hBEEF || ld_hit !== 1'b1 || ld_data !== 32'hBEEF) begin miscompares++; $display("FAIL starve_force_data: got addr=%h wdata=%h hit=%b data=%h want 0050 beef 1 beef", dm_addr, dm_wdata, ld_hit, ld_data); end
    tick();
    @(negedge clk);
    vectors++; if (dm_re !== 1'b1 || ld_stall !== 1'b0 || dm_we !== 1'b0 || sb_empty !== 1'b1) begin miscompares++; $display("FAIL starve_granted: got re=%b stall=%b we=%b empty=%b want 1 0 0 1", dm_re, ld_stall, dm_we, sb_empty); end
    vectors++; if (dut.starve_cnt !== 2'd0) begin miscompares++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_drain_order();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        st_vld = 1'b1; st_addr = 16'h0030 + 16'(i); st_data = 32'(i + 1);
      end else begin
        idle_in();
      end
      @(negedge clk);
      if (i == 0) begin
        vectors++; if (dm_we !== 1'b0) begin miscompares++; $display("FAIL order_idle: got we=%b want 0", dm_we); end
      end else begin
        vectors++; if (dm_we !== 1'b1 || dm_addr !== 16'h0030 + 16'(i - 1) || dm_wdata !== 32'(i)) begin miscompares++; $display("FAIL order_w%0d: got we=%b addr=%h data=%h want 1 %h %h", i - 1, dm_we, dm_addr, dm_wdata, 16'h0030 + 16'(i - 1), 32'(i)); end
      end
      tick();
    end
    @(negedge clk);
    vectors++; if (sb_empty !== 1'b1 || dm_we !== 1'b0) begin miscompares++; $display("FAIL order_empty: got empty=%b we=%b want 1 0", sb_empty, dm_we); end
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      st_vld = 1'b1; st_addr = 16'h0100 + 16'(i); st_data = 32'hC000 + 32'(i);
      @(negedge clk);
      vectors++; if (sb_empty !== 1'b1 || dm_we !== 1'b0) begin miscompares++; $display("FAIL wrap_push%0d: got empty=%b we=%b want 1 0", i, sb_empty, dm_we); end
      tick();
      idle_in();
      @(negedge clk);
      vectors++; if (dm_we !== 1'b1 || dm_addr !== 16'h0100 + 16'(i) || dm_wdata !== 32'hC000 + 32'(i) || sb_empty !== 1'b0) begin miscompares++; $display("FAIL wrap_drain%0d: got we=%b addr=%h data=%h empty=%b want 1 %h %h 0", i, dm_we, dm_addr, dm_wdata, sb_empty, 16'h0100 + 16'(i), 32'hC000 + 32'(i)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        st_vld = 1'b1; st_addr = 16'h0200 + 16'(i); st_data = 32'hD000 + 32'(i);
      end else begin
        idle_in();
      end
      @(negedge clk);
      if (i > 0) begin
        vectors++; if (dm_we !== 1'b1 || dm_addr !== 16'h0200 + 16'(i - 1) || dm_wdata !== 32'hD000 + 32'(i - 1) || st_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_w%0d: got we=%b addr=%h data=%h rdy=%b want 1 %h %h 1", i - 1, dm_we, dm_addr, dm_wdata, st_rdy, 16'h0200 + 16'(i - 1), 32'hD000 + 32'(i - 1)); end
      end
      tick();
    end
    @(negedge clk);
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty: got %b want 1", sb_empty); end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_in();
    test_reset();
    test_reset_pending();
    test_fill();
    test_forward();
    test_starve();
    test_drain_order();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
